// File: rtl/barret_for_2633.sv
// Three-stage pipelined Barrett reducer: dout_r = din_a mod Q for any IN_W-bit unsigned operand.
// One operand per clock, fixed three-cycle latency, with the valid bit carried alongside the data.
module barret_for_2633 #(
    parameter int unsigned Q     = 2633,
    parameter int unsigned IN_W  = 23,
    parameter int unsigned OUT_W = 12,
    parameter int unsigned K     = 24,
    parameter int unsigned M     = 6371
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din_valid,
    input  logic [IN_W-1:0]  din_a,
    output logic             dout_valid,
    output logic [OUT_W-1:0] dout_r
);

    localparam int unsigned M_W  = $clog2(M + 1);
    localparam int unsigned P_W  = IN_W + M_W;
    localparam int unsigned QH_W = P_W - K;
    // One guard bit above x so that x - qh*Q stays exact.
    localparam int unsigned T_W  = IN_W + 1;

    // Conditional subtraction at full width; used as the first correction.
    function automatic logic [T_W-1:0] sub_q(input logic [T_W-1:0] v);
        return (v >= T_W'(Q)) ? (v - T_W'(Q)) : v;
    endfunction

    // Second (safety) correction, then narrowing to the result width.
    function automatic logic [OUT_W-1:0] sub_q_final(input logic [T_W-1:0] v);
        return OUT_W'((v >= T_W'(Q)) ? (v - T_W'(Q)) : v);
    endfunction

    logic            vld_p0;
    logic [IN_W-1:0] x_p0;
    logic [P_W-1:0]  p_p0;
    logic            vld_p1;
    logic [T_W-1:0]  t_p1;

    logic [QH_W-1:0] qh;
    logic [T_W-1:0]  qh_q;
    logic [T_W-1:0]  t_next;

    // Stage 1: capture x and the full-width product x*M
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p0 <= 1'b0;
            x_p0   <= '0;
            p_p0   <= '0;
        end else begin
            vld_p0 <= din_valid;
            x_p0   <= din_a;
            p_p0   <= P_W'(din_a) * P_W'(M);
        end
    end

    always_comb begin
        qh     = QH_W'(p_p0 >> K);
        qh_q   = T_W'(qh) * T_W'(Q);
        t_next = {1'b0, x_p0} - qh_q;
    end

    // Stage 2: partial remainder t = x - qh*Q, known to lie in [0, 2Q)
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_p1 <= 1'b0;
            t_p1   <= '0;
        end else begin
            vld_p1 <= vld_p0;
            t_p1   <= t_next;
        end
    end

    // Stage 3: two conditional corrections; result held while no valid operand arrives
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dout_valid <= 1'b0;
            dout_r     <= '0;
        end else begin
            dout_valid <= vld_p1;
            if (vld_p1) begin
                dout_r <= sub_q_final(sub_q(t_p1));
            end
        end
    end

endmodule

// File: tb/tb_barret_for_2633.sv
// Self-checking bench for barret_for_2633: directed vectors, bubbles, resets and random
// operands compared against plain x % 2633 through a three-deep expectation queue.
module tb_barret_for_2633;

    localparam int unsigned Q = 2633;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        din_valid = 1'b0;
    logic [22:0] din_a = '0;
    logic        dout_valid;
    logic [11:0] dout_r;

    always #5 clk = ~clk;

    barret_for_2633 dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din_valid  (din_valid),
        .din_a      (din_a),
        .dout_valid (dout_valid),
        .dout_r     (dout_r)
    );

    typedef struct {
        logic        v;
        int unsigned r;
    } exp_t;

    typedef struct {
        logic [22:0] x;
        int unsigned r;
    } vec_t;

    exp_t        exp_q[$];
    int unsigned last_r;
    int          checks = 0;
    int          errors = 0;
    vec_t        vecs[10];

    task automatic check(input string name, input int unsigned got, input int unsigned want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d (t=%0t)", name, got, want, $time);
        end
    endtask

    function automatic int unsigned ref_mod(input logic [22:0] x);
        int unsigned xi;
        xi = x;
        return xi % Q;
    endfunction

    // Drive one input, advance one edge, compare the output due from three edges back.
    task automatic cycle(input logic v, input logic [22:0] x, input int unsigned r);
        exp_t e;
        exp_t n;
        din_valid = v;
        din_a     = x;
        @(posedge clk);
        #1;
        n.v = v;
        n.r = r;
        exp_q.push_back(n);
        e = exp_q.pop_front();
        check("dout_valid", dout_valid, e.v);
        if (e.v) begin
            check("dout_r", dout_r, e.r);
            last_r = e.r;
        end else begin
            check("dout_r_hold", dout_r, last_r);
        end
        check("dout_r_range", (dout_r < 12'(Q)) ? 1 : 0, 1);
    endtask

    task automatic prime_model();
        exp_t idle;
        idle.v = 1'b0;
        idle.r = 0;
        exp_q.delete();
        exp_q.push_back(idle);
        exp_q.push_back(idle);
        last_r = 0;
    endtask

    task automatic hold_reset(input int n);
        rst_n     = 1'b0;
        din_valid = 1'b1;
        din_a     = 23'd1234;
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            check("rst_valid", dout_valid, 0);
            check("rst_r", dout_r, 0);
        end
        rst_n = 1'b1;
        prime_model();
    endtask

    initial begin
        vecs[0] = '{23'd0,       0};
        vecs[1] = '{23'd2632,    2632};
        vecs[2] = '{23'd2633,    0};
        vecs[3] = '{23'd5265,    2632};
        vecs[4] = '{23'd5266,    0};
        vecs[5] = '{23'd6932688, 2632};
        vecs[6] = '{23'd8388607, 2502};
        vecs[7] = '{23'd2634,    1};
        vecs[8] = '{23'd7000,    1734};
        vecs[9] = '{23'd7899,    0};

        hold_reset(4);
        cycle(1'b1, 23'd5, 5);
        for (int i = 0; i < 3; i++) cycle(1'b0, 23'd0, 0);

        for (int i = 0; i < int'(Q); i++) cycle(1'b1, 23'(i), i);

        for (int i = 0; i < 10; i++) cycle(1'b1, vecs[i].x, vecs[i].r);
        for (int i = 9; i >= 0; i--) begin
            cycle(1'b1, vecs[i].x, vecs[i].r);
            cycle(1'b0, 23'h7fffff, 0);
        end

        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 23'd2634, 1);
            cycle(1'b0, 23'd2634, 0);
            cycle(1'b1, 23'd7000, 1734);
            cycle(1'b0, 23'd7000, 0);
        end

        cycle(1'b1, 23'd100, 100);
        cycle(1'b1, 23'd200, 200);
        cycle(1'b1, 23'd300, 300);
        hold_reset(1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 23'd300, 0);
        cycle(1'b1, 23'd4000, 1367);
        for (int i = 0; i < 3; i++) cycle(1'b0, 23'd0, 0);

        for (int i = 0; i < 20000; i++) begin
            logic [22:0] x;
            logic        v;
            x = 23'($urandom_range(0, 32'h7fffff));
            v = ($urandom_range(0, 7) != 0);
            cycle(v, x, ref_mod(x));
        end
        for (int i = 0; i < 3; i++) cycle(1'b0, 23'd0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
